sync_tx: RTL and testbench



---
 rtl/sync_tx_pkg.sv | 18 +
 rtl/nrzi_stuff_enc.sv | 27 ++
 rtl/sync_tx.sv | 137 +++++++++++++
 tb/tb_sync_tx.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/sync_tx_pkg.sv
// Shared line codes, FSM states and defaults for the sync_tx line transmitter.
package sync_tx_pkg;
  // Line states as {k, j}; 2'b11 is never driven.
  localparam logic [1:0] LINE_J   = 2'b01;
  localparam logic [1:0] LINE_K   = 2'b10;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP, EOPJ} tx_state_e;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_SYNC_LEN  = 8;
  localparam int DEF_STUFF_RUN = 6;
  localparam int DEF_EOP_SE0   = 2;

  function automatic logic [1:0] line_toggle(input logic [1:0] l);
    return (l == LINE_K) ? LINE_J : LINE_K;
  endfunction
endpackage

// File: rtl/nrzi_stuff_enc.sv
// NRZI encoder: a 1 holds the line, a 0 or stuff toggles it; tracks the run of 1s.
module nrzi_stuff_enc import sync_tx_pkg::*; #(
  parameter int STUFF_RUN = DEF_STUFF_RUN,
  parameter int CNT_W     = 4
)(
  input  logic       CLK,
  input  logic       RST,
  input  logic       clr,
  input  logic       bit_valid,
  input  logic       bit_in,
  input  logic       stuff_en,
  input  logic [1:0] line_cur,
  output logic [1:0] line_next,
  output logic       stuff_req
);
  logic [CNT_W-1:0] ones;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                 ones <= '0;
    else if (clr || stuff_en) ones <= '0;
    else if (bit_valid)       ones <= bit_in ? ones + 1'b1 : '0;
  end

  assign line_next = (bit_valid && bit_in) ? line_cur : line_toggle(line_cur);
  // Run already on the line has reached the limit: the next slot must be a stuff.
  assign stuff_req = (ones == CNT_W'(STUFF_RUN));
endmodule

// File: rtl/sync_tx.sv
// sync_tx: SYNC + NRZI/bit-stuffed payload (LSB first) + EOP on the k/j line pair.
module sync_tx import sync_tx_pkg::*; #(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int SYNC_LEN  = DEF_SYNC_LEN,
  parameter int STUFF_RUN = DEF_STUFF_RUN,
  parameter int EOP_SE0   = DEF_EOP_SE0
)(
  input  logic              CLK,
  input  logic              RST,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              k,
  output logic              j,
  output logic              tx_en
);
  localparam int M1    = (DATA_W > SYNC_LEN) ? DATA_W : SYNC_LEN;
  localparam int M2    = (M1 > STUFF_RUN) ? M1 : STUFF_RUN;
  localparam int M3    = (M2 > EOP_SE0) ? M2 : EOP_SE0;
  localparam int CNT_W = $clog2(M3 + 1);

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] SYNC_ALT  = CNT_W'(SYNC_LEN - 2);
  localparam logic [CNT_W-1:0] DATA_END  = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] EOP_END   = CNT_W'(EOP_SE0);

  tx_state_e         state, state_n;
  logic [CNT_W-1:0]  cyc, cyc_n, bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0] sh, sh_n;
  logic [1:0]        line, line_n, line_next;
  logic              en_n, busy_n, done_n;
  logic              bit_valid, stuff_en, stuff_req, clr;

  // Alternating K/J from index 0, the final two slots both K.
  function automatic logic [1:0] sync_sym(input logic [CNT_W-1:0] c);
    return (c >= SYNC_ALT || !c[0]) ? LINE_K : LINE_J;
  endfunction

  // Emission strobes kept outside the FSM block so the encoder feeds back without a comb loop.
  assign bit_valid = (state == SYNC  && cyc == SYNC_LAST) ||
                     (state == DATA  && !stuff_req && bit_cnt != DATA_END) ||
                     (state == STUFF && bit_cnt != DATA_END);
  assign stuff_en  = (state == DATA) && stuff_req;
  assign clr       = (state == IDLE);

  nrzi_stuff_enc #(.STUFF_RUN(STUFF_RUN), .CNT_W(CNT_W)) u_enc (
    .CLK(CLK), .RST(RST), .clr(clr), .bit_valid(bit_valid), .bit_in(sh[0]),
    .stuff_en(stuff_en), .line_cur(line), .line_next(line_next), .stuff_req(stuff_req)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      cyc     <= '0;
      bit_cnt <= '0;
      sh      <= '0;
      line    <= LINE_J;
      tx_en   <= 1'b0;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_n;
      cyc     <= cyc_n;
      bit_cnt <= bit_cnt_n;
      sh      <= sh_n;
      line    <= line_n;
      tx_en   <= en_n;
      tx_busy <= busy_n;
      tx_done <= done_n;
    end
  end

  // Next values describe what the line shows in the following cycle.
  always_comb begin
    state_n   = state;
    cyc_n     = cyc;
    bit_cnt_n = bit_cnt;
    sh_n      = sh;
    line_n    = line;
    en_n      = tx_en;
    busy_n    = tx_busy;
    done_n    = 1'b0;
    if (bit_valid) begin
      state_n   = DATA;
      line_n    = line_next;
      sh_n      = sh >> 1;
      bit_cnt_n = bit_cnt + 1'b1;
    end else begin
      case (state)
        IDLE: if (tx_start) begin
          state_n   = SYNC;
          sh_n      = tx_data;
          cyc_n     = '0;
          bit_cnt_n = '0;
          line_n    = LINE_K;
          en_n      = 1'b1;
          busy_n    = 1'b1;
        end
        SYNC: begin
          cyc_n  = cyc + 1'b1;
          line_n = sync_sym(cyc + 1'b1);
        end
        DATA, STUFF: begin
          if (stuff_en) begin
            state_n = STUFF;
            line_n  = line_next;
          end else begin
            state_n = EOP;
            cyc_n   = CNT_W'(1);
            line_n  = LINE_SE0;
          end
        end
        EOP: begin
          if (cyc == EOP_END) begin
            state_n = EOPJ;
            line_n  = LINE_J;
          end else begin
            cyc_n   = cyc + 1'b1;
          end
        end
        EOPJ: begin
          state_n = IDLE;
          cyc_n   = '0;
          line_n  = LINE_J;
          en_n    = 1'b0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign k = line[1];
  assign j = line[0];
endmodule

// File: tb/tb_sync_tx.sv
// Directed bench for sync_tx: table of payloads with hand-written line sequences plus corner cases.
module tb_sync_tx;
  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_busy, tx_done, k, j, tx_en;

  int checks = 0;
  int errors = 0;

  sync_tx dut (
    .CLK(CLK), .RST(RST), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done), .k(k), .j(j), .tx_en(tx_en)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    string      seq;   // K, J, S(E0) per tx_en-high cycle
  } vec_t;

  vec_t vecs[6];

  function automatic byte sym();
    case ({k, j})
      2'b10:   return "K";
      2'b01:   return "J";
      2'b00:   return "S";
      default: return "X";
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_sym(input string nm, input byte act, input byte exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %c expected %c", nm, act, exp);
    end
  endtask

  // Launch one packet and compare every tx_en-high cycle; pulse tx_start at slot pulse_at.
  task automatic run_vec(input int idx, input int pulse_at);
    int  n;
    byte s;
    @(negedge CLK);
    tx_data  = vecs[idx].data;
    tx_start = 1'b1;
    @(negedge CLK);
    tx_start = 1'b0;
    tx_data  = ~vecs[idx].data;
    n = 0;
    while (tx_en === 1'b1 && n < 40) begin
      s = sym();
      if (n < vecs[idx].seq.len())
        chk_sym($sformatf("v%0d sym%0d", idx, n), s, vecs[idx].seq[n]);
      chk($sformatf("v%0d busy%0d", idx, n), tx_busy, 1);
      chk($sformatf("v%0d done_early%0d", idx, n), tx_done, 0);
      tx_start = (n == pulse_at);
      n++;
      @(negedge CLK);
    end
    tx_start = 1'b0;
    chk($sformatf("v%0d len", idx), n, vecs[idx].seq.len());
    chk($sformatf("v%0d done", idx), tx_done, 1);
    chk($sformatf("v%0d busy_end", idx), tx_busy, 0);
    chk_sym($sformatf("v%0d idle_line", idx), sym(), "J");
    @(negedge CLK);
    chk($sformatf("v%0d done_once", idx), tx_done, 0);
    chk($sformatf("v%0d en_off", idx), tx_en, 0);
  endtask

  initial begin
    int n;
    vecs[0] = '{8'h00, {"KJKJKJKK", "JKJKJKJK", "SSJ"}};
    vecs[1] = '{8'hFF, {"KJKJKJKK", "KKKKKK", "J", "JJ", "SSJ"}};
    vecs[2] = '{8'h3F, {"KJKJKJKK", "KKKKKK", "J", "KJ", "SSJ"}};
    vecs[3] = '{8'hA5, {"KJKJKJKK", "KJJKJJKK", "SSJ"}};
    vecs[4] = '{8'h55, {"KJKJKJKK", "KJJKKJJK", "SSJ"}};
    vecs[5] = '{8'h7F, {"KJKJKJKK", "KKKKKK", "J", "JK", "SSJ"}};

    // Reset state, then a quiet idle line.
    repeat (2) @(negedge CLK);
    chk_sym("rst line", sym(), "J");
    chk("rst en", tx_en, 0);
    chk("rst busy", tx_busy, 0);
    chk("rst done", tx_done, 0);
    RST = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      chk_sym($sformatf("idle line%0d", c), sym(), "J");
      chk($sformatf("idle en%0d", c), tx_en, 0);
      chk($sformatf("idle busy%0d", c), tx_busy, 0);
    end

    for (int v = 0; v < 6; v++) run_vec(v, -1);

    // tx_start pulsed mid-DATA must not disturb the packet.
    run_vec(0, 10);
    run_vec(1, 12);

    // tx_start held: one IDLE cycle, then the next SYNC K.
    @(negedge CLK);
    tx_data  = 8'h00;
    tx_start = 1'b1;
    @(negedge CLK);
    n = 0;
    while (tx_en === 1'b1 && n < 40) begin n++; @(negedge CLK); end
    chk("held len1", n, 19);
    chk("held gap en", tx_en, 0);
    chk("held gap done", tx_done, 1);
    chk_sym("held gap line", sym(), "J");
    @(negedge CLK);
    chk("held restart en", tx_en, 1);
    chk("held restart busy", tx_busy, 1);
    chk_sym("held restart line", sym(), "K");
    tx_start = 1'b0;
    n = 0;
    while (tx_en === 1'b1 && n < 40) begin n++; @(negedge CLK); end
    chk("held len2", n, 19);
    chk("held done2", tx_done, 1);
    @(negedge CLK);

    // Asynchronous reset in the middle of DATA aborts with no tx_done.
    @(negedge CLK);
    tx_data  = 8'hA5;
    tx_start = 1'b1;
    @(negedge CLK);
    tx_start = 1'b0;
    repeat (10) @(negedge CLK);
    chk("abort pre en", tx_en, 1);
    #2 RST = 1'b0;
    #1;
    chk_sym("abort line", sym(), "J");
    chk("abort en", tx_en, 0);
    chk("abort busy", tx_busy, 0);
    chk("abort done", tx_done, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk($sformatf("abort hold done%0d", c), tx_done, 0);
      chk($sformatf("abort hold en%0d", c), tx_en, 0);
    end
    RST = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      chk($sformatf("post rst done%0d", c), tx_done, 0);
      chk_sym($sformatf("post rst line%0d", c), sym(), "J");
    end
    run_vec(0, -1);

    repeat (3) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
